mac_sequencer: RTL



---
 rtl/mac_sequencer_if.sv | 30 +++
 rtl/mac_sequencer.sv | 104 ++++++++++
 2 files changed

// File: rtl/mac_sequencer_if.sv
// mac_sequencer_if: control, operand-RAM, MAC and result signals of one dot-product sequencer.
interface mac_sequencer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                    start;
    logic [ADDR_WIDTH:0]     len;
    logic                    busy;
    logic                    rd_en;
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic [DATA_WIDTH-1:0]   op_a;
    logic [DATA_WIDTH-1:0]   op_b;
    logic [DATA_WIDTH-1:0]   mac_num_1;
    logic [DATA_WIDTH-1:0]   mac_num_2;
    logic                    mac_en;
    logic                    mac_clear;
    logic [2*DATA_WIDTH:0]   mac_result;
    logic [2*DATA_WIDTH:0]   result;
    logic                    result_valid;
    logic                    result_ready;

    modport master (
        input  start, len, op_a, op_b, mac_result, result_ready,
        output busy, rd_en, rd_addr, mac_num_1, mac_num_2, mac_en, mac_clear, result, result_valid
    );
    modport slave (
        output start, len, op_a, op_b, mac_result, result_ready,
        input  busy, rd_en, rd_addr, mac_num_1, mac_num_2, mac_en, mac_clear, result, result_valid
    );
endinterface

// File: rtl/mac_sequencer.sv
// mac_sequencer: drives one dot-product pass through a registered MAC and returns the sum.
// Optional MAC_SEQUENCER_ABORT_EN adds an abort input that cancels a pass in flight.
module mac_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int MAC_LAT    = 2
) (
    input logic clk,
    input logic reset,
`ifdef MAC_SEQUENCER_ABORT_EN
    input logic abort,
`endif
    mac_sequencer_if.master bus
);
    typedef enum logic [2:0] {IDLE, CLEAR, FETCH, DRAIN, DONE} state_t;

    // DRAIN covers the operand register stage, the MAC latency and one settle cycle
    localparam logic [ADDR_WIDTH:0] DRAIN_LAST = (ADDR_WIDTH+1)'(MAC_LAT + 2);

    state_t              state;
    logic [ADDR_WIDTH:0] cnt;
    logic [ADDR_WIDTH:0] len_r;
    logic                dv;
    logic                clr;

    assign bus.mac_clear = reset | clr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            cnt              <= '0;
            len_r            <= '0;
            dv               <= 1'b0;
            clr              <= 1'b0;
            bus.busy         <= 1'b0;
            bus.rd_en        <= 1'b0;
            bus.rd_addr      <= '0;
            bus.mac_num_1    <= DATA_WIDTH'(0);
            bus.mac_num_2    <= DATA_WIDTH'(0);
            bus.mac_en       <= 1'b0;
            bus.result       <= (2*DATA_WIDTH+1)'(0);
            bus.result_valid <= 1'b0;
        end else begin
            dv         <= bus.rd_en;
            bus.mac_en <= dv;
            clr        <= 1'b0;
            if (dv) begin
                bus.mac_num_1 <= bus.op_a;
                bus.mac_num_2 <= bus.op_b;
            end
            case (state)
                IDLE: if (bus.start) begin
                    bus.busy <= 1'b1;
                    len_r    <= bus.len;
                    if (bus.len == '0) begin
                        state            <= DONE;
                        bus.result       <= '0;
                        bus.result_valid <= 1'b1;
                    end else begin
                        state <= CLEAR;
                        clr   <= 1'b1;
                    end
                end
                CLEAR: begin
                    state       <= FETCH;
                    bus.rd_en   <= 1'b1;
                    bus.rd_addr <= '0;
                    cnt         <= (ADDR_WIDTH+1)'(1);
                end
                FETCH: if (cnt == len_r) begin
                    state     <= DRAIN;
                    bus.rd_en <= 1'b0;
                    cnt       <= '0;
                end else begin
                    bus.rd_addr <= cnt[ADDR_WIDTH-1:0];
                    cnt         <= cnt + 1'b1;
                end
                DRAIN: if (cnt == DRAIN_LAST) begin
                    state            <= DONE;
                    bus.result       <= bus.mac_result;
                    bus.result_valid <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                DONE: if (bus.result_ready) begin
                    state            <= IDLE;
                    bus.result_valid <= 1'b0;
                    bus.busy         <= 1'b0;
                end
                default: state <= IDLE;
            endcase
`ifdef MAC_SEQUENCER_ABORT_EN
            if (abort && (state == CLEAR || state == FETCH || state == DRAIN)) begin
                state      <= IDLE;
                bus.rd_en  <= 1'b0;
                bus.mac_en <= 1'b0;
                dv         <= 1'b0;
                clr        <= 1'b1;
                bus.busy   <= 1'b0;
            end
`endif
        end
    end
endmodule
